branch1_fetch_ctrl: RTL and testbench
=====================================

Name: branch1_fetch_ctrl

Overview:
- Upstream feeder of the branch-1 calc stage in the SISO decoder.
- On a start pulse, sweeps all BRANCH_SIZE addresses of the systematic and parity item RAMs, forward or reverse.
- Aligns each returned RAM word pair with its address and a valid strobe, and presents a (sys, parity, addr, valid) stream for the calc stage.
- Reports busy and done to the decoder controller.

Parameters:
- DWIDTH, 16, signed LLR item width.
- BRANCH_SIZE, 3072, items per block; AW = $clog2(BRANCH_SIZE).
- RAM_LATENCY, 1, read latency of both item RAMs in cycles, legal range 1..4.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse.
- i_reverse  in  1  sweep order, sampled with i_start: 0 = 0→BRANCH_SIZE-1, 1 = BRANCH_SIZE-1→0.
- i_hold  in  1  stall read issue while high.
- o_rd_en  out  1  read enable to both RAMs.
- o_rd_addr  out  AW  read address to both RAMs.
- i_sys_rdata  in  DWIDTH  sys RAM read data, valid RAM_LATENCY cycles after o_rd_en.
- i_parity_rdata  in  DWIDTH  parity RAM read data, same timing.
- o_sys_item  out  DWIDTH  signed sys item to calc stage.
- o_parity_item  out  DWIDTH  signed parity item.
- o_addr  out  AW  item address matching the data.
- o_valid  out  1  data/addr qualifier.
- o_busy  out  1  high from the cycle after an accepted start until done.
- o_done  out  1  one-cycle pulse when the sweep has fully drained.

Behaviour:
- Reset (asynchronous, aresetn low): all outputs 0, FSM to IDLE, counters and delay line cleared. Reset mid-sweep aborts the sweep; no done pulse is produced.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - i_start=1 latches i_reverse, loads the counter (0, or BRANCH_SIZE-1 if reverse), clears the issue count, goes to READ.
  - i_start is ignored in every other state.
- READ, each cycle with i_hold=0:
  - o_rd_en=1 and o_rd_addr=counter.
  - Counter steps +1 (forward) or -1 (reverse); issue count +1.
  - On the cycle that issues the BRANCH_SIZE-th read, go to DRAIN.
- READ with i_hold=1: o_rd_en=0; counter and issue count frozen; in-flight reads continue to complete.
- o_rd_en is registered and o_rd_addr is held between reads. With no hold, o_rd_en is high for exactly BRANCH_SIZE consecutive cycles.
- Delay line: RAM_LATENCY-deep shift of {rd_en, rd_addr}. Output stage is one register.
  - A read issued at cycle t with address a gives o_valid=1, o_addr=a at t+RAM_LATENCY+1.
  - In that same cycle, o_sys_item and o_parity_item are the RAM data registered at t+RAM_LATENCY.
  - When o_valid=0, data outputs hold their last value.
- DRAIN: stay until the delay line and output stage carry no valid. Then go to DONE.
- DONE: o_done=1 for one cycle, in the cycle after the last o_valid. Then return to IDLE.
- o_busy=1 in READ, DRAIN and DONE; 0 in IDLE.
- i_start in the DONE cycle is ignored. A new start is accepted from IDLE no earlier than the following cycle.
- Address sequencing:
  - The counter never wraps within a sweep.
  - Forward ends at BRANCH_SIZE-1; reverse ends at 0.
  - Non-power-of-2 BRANCH_SIZE: the end is detected by the issue count, never by address overflow.
- Data is passed through unmodified (signed, DWIDTH bits); no arithmetic is performed.
- No backpressure from downstream; the calc stage always accepts.

Decomposition:
- Shared package siso_pkg holds:
  - the FSM state encoding (IDLE, READ, DRAIN, DONE, 2 bits);
  - the AW computation helper;
  - the defaults DWIDTH=16 and BRANCH_SIZE=3072, shared with branch1_calc_service.
- One sub-module: siso_valid_delay, a parameterised shift register of {valid, addr} of depth RAM_LATENCY with asynchronous clear. It is reused by other fetch controllers.

Test Plan:
- BRANCH_SIZE=8, RAM_LATENCY=2, forward, start at cycle 0, RAM model data=addr*3:
  - o_rd_en high for cycles 1..8 with addresses 0..7.
  - o_valid high for cycles 4..11 with o_addr 0..7 and o_sys_item 0,3,..,21.
  - o_done pulse at cycle 12; o_busy high for cycles 1..12.
- Same setup with i_reverse=1: o_addr sequence 7,6,..,0; data 21..0; done at cycle 12.
- i_hold high for cycles 3-4 during forward sweep:
  - no reads in those cycles; addresses stay gapless in order 0..7;
  - total of 8 valids; done at cycle 14.
- i_start re-pulsed at cycles 5 and 12 (busy/DONE): ignored; exactly one sweep of 8 valids. A start at cycle 13 launches a second full sweep.
- aresetn low at cycle 6 mid-sweep:
  - all outputs 0 immediately (asynchronously);
  - no o_done; FSM in IDLE after release;
  - a subsequent start performs a clean sweep.
- BRANCH_SIZE=3072, RAM_LATENCY=1, random signed data including -32768 and 32767: the scoreboard matches all 3072 items bit-exact in order; done follows the last valid by 1 cycle.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared SISO decoder types: FSM encoding, address-width helper, block defaults.
// Used by the branch-1 fetch controller and the calc service.
// No logic; pure declarations.
package siso_pkg;

    localparam int SISO_DWIDTH      = 16;
    localparam int SISO_BRANCH_SIZE = 3072;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } siso_state_t;

    function automatic int siso_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/branch1_fetch_ctrl_if.sv
// Item-RAM read port plus the (sys, parity, addr, valid) stream to the calc stage.
// Latency: n/a (wires only).
// Backpressure: none; the calc stage always accepts.
interface branch1_fetch_ctrl_if
    import siso_pkg::*;
#(
    parameter int DWIDTH = SISO_DWIDTH,
    parameter int AW     = siso_aw(SISO_BRANCH_SIZE)
);
    logic                     o_rd_en;
    logic [AW-1:0]            o_rd_addr;
    logic signed [DWIDTH-1:0] i_sys_rdata;
    logic signed [DWIDTH-1:0] i_parity_rdata;
    logic signed [DWIDTH-1:0] o_sys_item;
    logic signed [DWIDTH-1:0] o_parity_item;
    logic [AW-1:0]            o_addr;
    logic                     o_valid;

    modport master (
        output o_rd_en, o_rd_addr, o_sys_item, o_parity_item, o_addr, o_valid,
        input  i_sys_rdata, i_parity_rdata
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_sys_item, o_parity_item, o_addr, o_valid,
        output i_sys_rdata, i_parity_rdata
    );
endinterface

// File: rtl/siso_valid_delay.sv
// Shift register of {valid, addr} tracking reads in flight through an item RAM.
// Latency: DEPTH cycles.
// Backpressure: none; shifts every cycle.
module siso_valid_delay #(
    parameter int DEPTH = 1,
    parameter int AW    = 12
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    output logic [AW-1:0] out_addr,
    output logic          any_vld
);
    logic [DEPTH-1:0] vld_sr;
    logic [AW-1:0]    addr_sr [DEPTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_sr <= '0;
            for (int i = 0; i < DEPTH; i++) addr_sr[i] <= '0;
        end else begin
            vld_sr[0]  <= in_vld;
            addr_sr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    assign out_vld  = vld_sr[DEPTH-1];
    assign out_addr = addr_sr[DEPTH-1];
    assign any_vld  = |vld_sr;
endmodule

// File: rtl/branch1_fetch_ctrl.sv
// Sweeps the sys/parity item RAMs and streams address-aligned items to branch-1 calc.
// Latency: item appears RAM_LATENCY+1 cycles after its read issue; done 1 cycle after last valid.
// Backpressure: none downstream; i_hold stalls read issue only.
module branch1_fetch_ctrl
    import siso_pkg::*;
#(
    parameter int DWIDTH      = SISO_DWIDTH,
    parameter int BRANCH_SIZE = SISO_BRANCH_SIZE,
    parameter int RAM_LATENCY = 1,
    localparam int AW         = siso_aw(BRANCH_SIZE)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        i_start,
    input  logic                        i_reverse,
    input  logic                        i_hold,
    branch1_fetch_ctrl_if.master        bus,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int CW = siso_aw(BRANCH_SIZE + 1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(BRANCH_SIZE - 1);
    localparam logic [CW-1:0] ISSUE_LAST = CW'(BRANCH_SIZE - 1);

    siso_state_t  state;
    logic         rev;
    logic [AW-1:0] cnt;
    logic [CW-1:0] issued;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [AW-1:0] first_addr, issue_addr, step_addr;
    logic [CW-1:0] issue_base;
    logic          issue_go, issue_last, dir_rev;

    // The first read goes out on the same edge that accepts the start.
    always_comb begin
        first_addr = i_reverse ? ADDR_LAST : '0;
        dir_rev    = (state == ST_IDLE) ? i_reverse : rev;
        issue_addr = (state == ST_IDLE) ? first_addr : cnt;
        issue_base = (state == ST_IDLE) ? '0 : issued;
        issue_go   = !i_hold && ((state == ST_IDLE && i_start) || state == ST_READ);
        issue_last = (issue_base == ISSUE_LAST);
        step_addr  = dir_rev ? issue_addr - AW'(1) : issue_addr + AW'(1);
    end

    logic          dl_vld, dl_any;
    logic [AW-1:0] dl_addr;

    siso_valid_delay #(.DEPTH(RAM_LATENCY), .AW(AW)) u_delay (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_vld   (rd_en),
        .in_addr  (rd_addr),
        .out_vld  (dl_vld),
        .out_addr (dl_addr),
        .any_vld  (dl_any)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            rev     <= 1'b0;
            cnt     <= '0;
            issued  <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            rd_en  <= 1'b0;
            o_done <= 1'b0;
            case (state)
                ST_IDLE: if (i_start) begin
                    rev    <= i_reverse;
                    cnt    <= first_addr;
                    issued <= '0;
                    o_busy <= 1'b1;
                    state  <= ST_READ;
                end
                ST_READ: ;
                // rd_en and the delay line empty means the output stage holds the last item.
                ST_DRAIN: if (!rd_en && !dl_any) begin
                    o_done <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (issue_go) begin
                rd_en   <= 1'b1;
                rd_addr <= issue_addr;
                issued  <= issue_base + CW'(1);
                if (issue_last) state <= ST_DRAIN;
                else            cnt   <= step_addr;
            end
        end
    end

    logic                     out_vld;
    logic [AW-1:0]            out_addr;
    logic signed [DWIDTH-1:0] out_sys, out_par;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld  <= 1'b0;
            out_addr <= '0;
            out_sys  <= '0;
            out_par  <= '0;
        end else begin
            out_vld <= dl_vld;
            if (dl_vld) begin
                out_addr <= dl_addr;
                out_sys  <= bus.i_sys_rdata;
                out_par  <= bus.i_parity_rdata;
            end
        end
    end

    assign bus.o_rd_en       = rd_en;
    assign bus.o_rd_addr     = rd_addr;
    assign bus.o_valid       = out_vld;
    assign bus.o_addr        = out_addr;
    assign bus.o_sys_item    = out_sys;
    assign bus.o_parity_item = out_par;
endmodule

// File: tb/tb_branch1_fetch_ctrl.sv
// Bench for branch1_fetch_ctrl: small block (8 items, latency 2) from a vector table
// plus reset abort, and a full 3072-item block with random data and holds.
module tb_branch1_fetch_ctrl;
    import siso_pkg::*;

    localparam int NS = 8;
    localparam int NL = 3072;

    logic aclk;
    logic rst_s_n, start_s, rev_s, hold_s, busy_s, done_s;
    logic rst_l_n, start_l, rev_l, hold_l, busy_l, done_l;

    branch1_fetch_ctrl_if #(.DWIDTH(16), .AW(siso_aw(NS))) bus_s ();
    branch1_fetch_ctrl_if #(.DWIDTH(16), .AW(siso_aw(NL))) bus_l ();

    branch1_fetch_ctrl #(.DWIDTH(16), .BRANCH_SIZE(NS), .RAM_LATENCY(2)) dut_s (
        .aclk(aclk), .aresetn(rst_s_n), .i_start(start_s), .i_reverse(rev_s),
        .i_hold(hold_s), .bus(bus_s), .o_busy(busy_s), .o_done(done_s));

    branch1_fetch_ctrl #(.DWIDTH(16), .BRANCH_SIZE(NL), .RAM_LATENCY(1)) dut_l (
        .aclk(aclk), .aresetn(rst_l_n), .i_start(start_l), .i_reverse(rev_l),
        .i_hold(hold_l), .bus(bus_l), .o_busy(busy_l), .o_done(done_l));

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Small RAM pair: two-cycle latency, sys = addr*3, parity = -addr*3.
    logic signed [15:0] s_p1_sys, s_p1_par;
    always @(posedge aclk) begin
        s_p1_sys <= 16'(3 * int'(bus_s.o_rd_addr));
        s_p1_par <= 16'(-3 * int'(bus_s.o_rd_addr));
        bus_s.i_sys_rdata    <= s_p1_sys;
        bus_s.i_parity_rdata <= s_p1_par;
    end

    logic signed [15:0] mem_sys [NL];
    logic signed [15:0] mem_par [NL];
    always @(posedge aclk) begin
        bus_l.i_sys_rdata    <= mem_sys[bus_l.o_rd_addr];
        bus_l.i_parity_rdata <= mem_par[bus_l.o_rd_addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        bit rev;
        int hold_lo, hold_hi;
        int st0, st1, st2, st3;   // cycles with i_start high (-1 unused)
        int acc0, acc1;           // starts expected to be accepted (-1 unused)
        int ncyc;
        int first_v;
        int done0, done1;
        bit exact_rd;
    } vec_t;

    vec_t vecs[4];

    task automatic apply_vec(input vec_t v, input string tag);
        bit t_rd[64], t_vld[64], t_busy[64], t_done[64];
        int t_rda[64], t_addr[64], t_sys[64], t_par[64];
        int ns, nv, nd, nrd, first, last, busy_bad, rd_bad, ea;
        int dcy[2];
        bit eb, er;
        for (int c = 0; c < v.ncyc; c++) begin
            @(posedge aclk); #1;
            start_s = (c == v.st0 || c == v.st1 || c == v.st2 || c == v.st3);
            hold_s  = (c >= v.hold_lo && c <= v.hold_hi);
            rev_s   = v.rev;
            @(negedge aclk);
            t_rd[c]   = bus_s.o_rd_en;   t_rda[c]  = int'(bus_s.o_rd_addr);
            t_vld[c]  = bus_s.o_valid;   t_addr[c] = int'(bus_s.o_addr);
            t_sys[c]  = int'(bus_s.o_sys_item);
            t_par[c]  = int'(bus_s.o_parity_item);
            t_busy[c] = busy_s;          t_done[c] = done_s;
        end
        start_s = 1'b0;
        hold_s  = 1'b0;
        ns = (v.acc1 >= 0) ? 2 : 1;
        nv = 0; nd = 0; nrd = 0; first = -1; last = -1; busy_bad = 0; rd_bad = 0;
        dcy[0] = -1; dcy[1] = -1;
        for (int c = 0; c < v.ncyc; c++) begin
            if (t_vld[c]) begin
                ea = v.rev ? (NS - 1 - (nv % NS)) : (nv % NS);
                check({tag, " o_addr"}, t_addr[c], ea);
                check({tag, " o_sys_item"}, t_sys[c], 3 * ea);
                check({tag, " o_parity_item"}, t_par[c], -3 * ea);
                if (first < 0) first = c;
                last = c;
                nv++;
            end
            if (t_rd[c]) begin
                ea = v.rev ? (NS - 1 - (nrd % NS)) : (nrd % NS);
                if (t_rda[c] != ea) rd_bad++;
                nrd++;
            end
            if (t_done[c]) begin
                if (nd < 2) dcy[nd] = c;
                nd++;
            end
            eb = (c >= 1 && c <= v.done0) || (v.done1 >= 0 && c >= v.acc1 + 1 && c <= v.done1);
            if (t_busy[c] != eb) busy_bad++;
            if (v.exact_rd) begin
                er = (c >= v.acc0 + 1 && c <= v.acc0 + NS) ||
                     (v.acc1 >= 0 && c >= v.acc1 + 1 && c <= v.acc1 + NS);
                if (t_rd[c] != er) rd_bad++;
            end
        end
        check({tag, " valid count"}, nv, NS * ns);
        check({tag, " read count"}, nrd, NS * ns);
        check({tag, " read pattern errors"}, rd_bad, 0);
        check({tag, " first valid cycle"}, first, v.first_v);
        check({tag, " done count"}, nd, ns);
        check({tag, " done cycle"}, dcy[0], v.done0);
        if (ns == 2) check({tag, " second done cycle"}, dcy[1], v.done1);
        check({tag, " done after last valid"}, dcy[ns-1], last + 1);
        check({tag, " busy pattern errors"}, busy_bad, 0);
        check({tag, " sys held after sweep"}, t_sys[v.ncyc-1], v.rev ? 0 : 3 * (NS - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, nv, last_v, done_c, nd;
        bit got_done;
        longint act, exp;

        rst_s_n = 1'b0; start_s = 1'b0; rev_s = 1'b0; hold_s = 1'b0;
        rst_l_n = 1'b0; start_l = 1'b0; rev_l = 1'b0; hold_l = 1'b0;

        vecs[0] = '{rev:1'b0, hold_lo:-1, hold_hi:-2, st0:0, st1:-1, st2:-1, st3:-1,
                    acc0:0, acc1:-1, ncyc:20, first_v:4, done0:12, done1:-1, exact_rd:1'b1};
        vecs[1] = '{rev:1'b1, hold_lo:-1, hold_hi:-2, st0:0, st1:-1, st2:-1, st3:-1,
                    acc0:0, acc1:-1, ncyc:20, first_v:4, done0:12, done1:-1, exact_rd:1'b1};
        vecs[2] = '{rev:1'b0, hold_lo:3, hold_hi:4, st0:0, st1:-1, st2:-1, st3:-1,
                    acc0:0, acc1:-1, ncyc:20, first_v:4, done0:14, done1:-1, exact_rd:1'b0};
        vecs[3] = '{rev:1'b0, hold_lo:-1, hold_hi:-2, st0:0, st1:5, st2:12, st3:13,
                    acc0:0, acc1:13, ncyc:32, first_v:4, done0:12, done1:25, exact_rd:1'b1};

        for (int i = 0; i < NL; i++) begin
            mem_sys[i] = 16'($urandom);
            mem_par[i] = 16'($urandom);
        end
        mem_sys[0] = 16'sh8000;   mem_par[0] = 16'sh7fff;
        mem_sys[7] = 16'sh7fff;   mem_par[7] = 16'sh8000;
        mem_sys[NL-1] = 16'sh8000; mem_par[NL-1] = 16'sh8000;

        @(negedge aclk);
        check("reset o_rd_en", bus_s.o_rd_en, 0);
        check("reset o_rd_addr", bus_s.o_rd_addr, 0);
        check("reset o_valid", bus_s.o_valid, 0);
        check("reset o_addr", bus_s.o_addr, 0);
        check("reset o_sys_item", bus_s.o_sys_item, 0);
        check("reset o_parity_item", bus_s.o_parity_item, 0);
        check("reset o_busy", busy_s, 0);
        check("reset o_done", done_s, 0);
        @(posedge aclk); #1;
        rst_s_n = 1'b1;
        rst_l_n = 1'b1;
        repeat (2) @(posedge aclk);

        for (int i = 0; i < 4; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted mid-sweep at cycle 6.
        for (int c = 0; c <= 6; c++) begin
            @(posedge aclk); #1;
            start_s = (c == 0);
            if (c == 5) begin
                #1;
                check("abort busy before reset", busy_s, 1);
            end
            if (c == 6) rst_s_n = 1'b0;
        end
        #1;
        check("abort o_rd_en", bus_s.o_rd_en, 0);
        check("abort o_valid", bus_s.o_valid, 0);
        check("abort o_addr", bus_s.o_addr, 0);
        check("abort o_sys_item", bus_s.o_sys_item, 0);
        check("abort o_parity_item", bus_s.o_parity_item, 0);
        check("abort o_busy", busy_s, 0);
        repeat (2) @(posedge aclk);
        #1;
        rst_s_n = 1'b1;
        nd = 0; nv = 0; r = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge aclk);
            nd += int'(done_s);
            nv += int'(bus_s.o_valid);
            r  += int'(busy_s);
        end
        check("abort done pulses", nd, 0);
        check("abort valids after release", nv, 0);
        check("abort busy after release", r, 0);
        apply_vec(vecs[0], "post_abort");

        // Full-size block, random data and random hold.
        r = int'($urandom_range(0, 1));
        @(posedge aclk); #1;
        start_l = 1'b1; rev_l = r[0]; hold_l = 1'b0;
        @(negedge aclk);
        nv = 0; last_v = -1; done_c = -1; nd = 0; got_done = 1'b0;
        for (int c = 1; c < 12000 && !got_done; c++) begin
            @(posedge aclk); #1;
            start_l = 1'b0;
            hold_l  = ($urandom_range(0, 7) == 0);
            @(negedge aclk);
            if (bus_l.o_valid) begin
                int ea;
                ea  = r[0] ? (NL - 1 - nv) : nv;
                act = longint'({bus_l.o_addr, bus_l.o_sys_item, bus_l.o_parity_item});
                exp = longint'({12'(ea), mem_sys[ea], mem_par[ea]});
                check($sformatf("big item %0d {addr,sys,par}", nv), act, exp);
                nv++;
                last_v = c;
            end
            if (done_l) begin
                got_done = 1'b1;
                done_c = c;
            end
        end
        hold_l = 1'b0;
        check("big done seen", got_done, 1);
        check("big valid count", nv, NL);
        check("big done after last valid", done_c, last_v + 1);
        @(negedge aclk);
        check("big done is one cycle", done_l, 0);
        @(negedge aclk);
        check("big idle after done", busy_l, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
